// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised 2R1W register file with write-pending scoreboard (optional REGFILE_BYPASS_EN forwarding)
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read1,
    input  logic [ADDR_W-1:0] read2,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic              busy1,
    output logic              busy2,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic              lockReq,
    input  logic [ADDR_W-1:0] lockReg,
    output logic [ADDR_W:0]   busyCount
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic              wr_en;
    logic              lk_en;
    logic              cnt_inc;
    logic              cnt_dec;

    // Writes and locks aimed at a hardwired zero register are dropped here
    always_comb begin
        wr_en = regWrite && !((ZERO_REG != 0) && (writeReg == '0));
        lk_en = lockReq  && !((ZERO_REG != 0) && (lockReg  == '0));
    end

    // Next busy vector: write clears, lock sets, and the lock wins on a collision
    always_comb begin
        busy_next = busy;
        if (wr_en) busy_next[writeReg] = 1'b0;
        if (lk_en) busy_next[lockReg]  = 1'b1;
    end

    // At most one rising and one falling busy bit per edge, so the counter moves by -1/0/+1
    always_comb begin
        cnt_inc = lk_en && !busy[lockReg];
        cnt_dec = wr_en && busy[writeReg] && !(lk_en && (lockReg == writeReg));
    end

    // Storage, busy vector and popcount register; reset clears everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy      <= '0;
            busyCount <= '0;
        end else begin
            if (wr_en) mem[writeReg] <= writeData;
            busy      <= busy_next;
            busyCount <= busyCount + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd1;
    logic fwd2;

    // Forward the in-flight write to a matching read port; a same-cycle relock keeps the stored busy bit
    always_comb begin
        fwd1  = wr_en && (writeReg == read1);
        fwd2  = wr_en && (writeReg == read2);
        data1 = fwd1 ? writeData : mem[read1];
        data2 = fwd2 ? writeData : mem[read2];
        busy1 = busy[read1];
        busy2 = busy[read2];
        if (fwd1 && !(lockReq && (lockReg == read1))) busy1 = 1'b0;
        if (fwd2 && !(lockReq && (lockReg == read2))) busy2 = 1'b0;
    end
`else
    // Reads come straight from storage; register 0 is never written or locked when hardwired
    always_comb begin
        data1 = mem[read1];
        data2 = mem[read2];
        busy1 = busy[read1];
        busy2 = busy[read2];
    end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard bench for regfile_sb
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  read1, read2;
    logic [31:0] data1, data2;
    logic        busy1, busy2;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        lockReq;
    logic [4:0]  lockReg;
    logic [5:0]  busyCount;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_data_q [$];
    logic        exp_busy_q [$];
    logic [5:0]  exp_cnt_q  [$];

    logic [31:0] ed;
    logic        eb;
    logic [5:0]  ec;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset),
        .read1(read1), .read2(read2),
        .data1(data1), .data2(data2),
        .busy1(busy1), .busy2(busy2),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .lockReq(lockReq), .lockReg(lockReg),
        .busyCount(busyCount)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drive one edge of write/lock stimulus from a negedge, return at the next negedge
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic lk, input logic [4:0] la);
        regWrite = we; writeReg = wa; writeData = wd;
        lockReq = lk; lockReg = la;
        @(posedge clk);
        #1;
        regWrite = 1'b0;
        lockReq  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        regWrite = 0; writeReg = 0; writeData = 0; lockReq = 0; lockReg = 0;
        read1 = 5'd5; read2 = 5'd31;
        #3;
        n_checks++; if (data1 !== 32'h0) begin n_fail++; $display("FAIL reset_data1 got %h exp 0", data1); end
        n_checks++; if (data2 !== 32'h0) begin n_fail++; $display("FAIL reset_data2 got %h exp 0", data2); end
        n_checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b%b exp 00", busy1, busy2); end
        n_checks++; if (busyCount !== 6'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", busyCount); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_write_read;
        read1 = 5'd3; read2 = 5'd31;
        exp_data_q.push_back(32'hA5A5A5A5);
        cycle(1, 5'd3, 32'hA5A5A5A5, 0, 0);
        ed = exp_data_q.pop_front();
        n_checks++; if (data1 !== ed) begin n_fail++; $display("FAIL wr_r3 got %h exp %h", data1, ed); end
        exp_data_q.push_back(32'h12345678);
        cycle(1, 5'd31, 32'h12345678, 0, 0);
        ed = exp_data_q.pop_front();
        n_checks++; if (data2 !== ed) begin n_fail++; $display("FAIL wr_r31 got %h exp %h", data2, ed); end
        read1 = 5'd0;
        exp_data_q.push_back(32'h0);
        exp_busy_q.push_back(1'b0);
        cycle(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0);
        ed = exp_data_q.pop_front();
        eb = exp_busy_q.pop_front();
        n_checks++; if (data1 !== ed) begin n_fail++; $display("FAIL wr_r0 got %h exp %h", data1, ed); end
        n_checks++; if (busy1 !== eb || busyCount !== 6'd0) begin n_fail++; $display("FAIL lock_r0 busy %b cnt %0d exp 0 0", busy1, busyCount); end
        read1 = 5'd3; read2 = 5'd3;
        #1;
        n_checks++; if (data1 !== 32'hA5A5A5A5 || data2 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL same_addr got %h %h exp a5a5a5a5", data1, data2); end
    endtask

    task automatic test_scoreboard;
        read1 = 5'd7;
        exp_cnt_q.push_back(6'd1);
        cycle(0, 0, 0, 1, 5'd7);
        ec = exp_cnt_q.pop_front();
        n_checks++; if (busyCount !== ec) begin n_fail++; $display("FAIL lock7_cnt got %0d exp %0d", busyCount, ec); end
        exp_cnt_q.push_back(6'd2);
        exp_busy_q.push_back(1'b1);
        cycle(0, 0, 0, 1, 5'd9);
        ec = exp_cnt_q.pop_front();
        eb = exp_busy_q.pop_front();
        n_checks++; if (busyCount !== ec) begin n_fail++; $display("FAIL lock9_cnt got %0d exp %0d", busyCount, ec); end
        n_checks++; if (busy1 !== eb) begin n_fail++; $display("FAIL busy7 got %b exp %b", busy1, eb); end
        exp_cnt_q.push_back(6'd1);
        exp_busy_q.push_back(1'b0);
        cycle(1, 5'd7, 32'h00000777, 0, 0);
        ec = exp_cnt_q.pop_front();
        eb = exp_busy_q.pop_front();
        n_checks++; if (busy1 !== eb || busyCount !== ec) begin n_fail++; $display("FAIL wr7 busy %b cnt %0d exp %b %0d", busy1, busyCount, eb, ec); end
        exp_cnt_q.push_back(6'd1);
        cycle(0, 0, 0, 1, 5'd9);
        ec = exp_cnt_q.pop_front();
        n_checks++; if (busyCount !== ec) begin n_fail++; $display("FAIL relock9 got %0d exp %0d", busyCount, ec); end
        exp_cnt_q.push_back(6'd1);
        cycle(1, 5'd3, 32'h33333333, 0, 0);
        ec = exp_cnt_q.pop_front();
        n_checks++; if (busyCount !== ec) begin n_fail++; $display("FAIL wr_nonbusy got %0d exp %0d", busyCount, ec); end
    endtask

    task automatic test_simultaneous;
        read1 = 5'd4; read2 = 5'd6;
        exp_data_q.push_back(32'h55);
        exp_busy_q.push_back(1'b1);
        exp_cnt_q.push_back(6'd2);
        cycle(1, 5'd4, 32'h55, 1, 5'd4);
        ed = exp_data_q.pop_front(); eb = exp_busy_q.pop_front(); ec = exp_cnt_q.pop_front();
        n_checks++; if (data1 !== ed || busy1 !== eb || busyCount !== ec) begin n_fail++; $display("FAIL lockwr4 got %h %b %0d exp %h %b %0d", data1, busy1, busyCount, ed, eb, ec); end
        exp_cnt_q.push_back(6'd3);
        cycle(1, 5'd6, 32'h66, 1, 5'd2);
        ec = exp_cnt_q.pop_front();
        n_checks++; if (busyCount !== ec || data2 !== 32'h66) begin n_fail++; $display("FAIL lock2wr6 cnt %0d d %h exp %0d 66", busyCount, data2, ec); end
        exp_cnt_q.push_back(6'd4);
        cycle(0, 0, 0, 1, 5'd6);
        ec = exp_cnt_q.pop_front();
        n_checks++; if (busyCount !== ec || busy2 !== 1'b1) begin n_fail++; $display("FAIL lock6 cnt %0d busy %b exp %0d 1", busyCount, busy2, ec); end
        exp_cnt_q.push_back(6'd4);
        exp_busy_q.push_back(1'b0);
        cycle(1, 5'd6, 32'h67, 1, 5'd11);
        ec = exp_cnt_q.pop_front(); eb = exp_busy_q.pop_front();
        n_checks++; if (busyCount !== ec || busy2 !== eb) begin n_fail++; $display("FAIL lock11wr6 cnt %0d busy %b exp %0d %b", busyCount, busy2, ec, eb); end
    endtask

    task automatic test_bypass;
        read1 = 5'd8;
        cycle(0, 0, 0, 1, 5'd8);
        n_checks++; if (busy1 !== 1'b1 || busyCount !== 6'd5) begin n_fail++; $display("FAIL lock8 busy %b cnt %0d exp 1 5", busy1, busyCount); end
        regWrite = 1'b1; writeReg = 5'd8; writeData = 32'hCAFE0001;
`ifdef REGFILE_BYPASS_EN
        exp_data_q.push_back(32'hCAFE0001);
        exp_busy_q.push_back(1'b0);
`else
        exp_data_q.push_back(32'h0);
        exp_busy_q.push_back(1'b1);
`endif
        #1;
        ed = exp_data_q.pop_front(); eb = exp_busy_q.pop_front();
        n_checks++; if (data1 !== ed || busy1 !== eb) begin n_fail++; $display("FAIL bypass_same_cycle got %h %b exp %h %b", data1, busy1, ed, eb); end
        @(posedge clk);
        #1;
        regWrite = 1'b0;
        @(negedge clk);
        n_checks++; if (data1 !== 32'hCAFE0001 || busy1 !== 1'b0 || busyCount !== 6'd4) begin n_fail++; $display("FAIL bypass_after_edge got %h %b %0d exp cafe0001 0 4", data1, busy1, busyCount); end
        regWrite = 1'b1; writeReg = 5'd8; writeData = 32'hCAFE0002;
        lockReq = 1'b1; lockReg = 5'd8;
        #1;
`ifdef REGFILE_BYPASS_EN
        ed = 32'hCAFE0002;
`else
        ed = 32'hCAFE0001;
`endif
        n_checks++; if (data1 !== ed || busy1 !== 1'b0) begin n_fail++; $display("FAIL bypass_relock got %h %b exp %h 0", data1, busy1, ed); end
        @(posedge clk);
        #1;
        regWrite = 1'b0; lockReq = 1'b0;
        @(negedge clk);
        n_checks++; if (data1 !== 32'hCAFE0002 || busy1 !== 1'b1 || busyCount !== 6'd5) begin n_fail++; $display("FAIL relock8 got %h %b %0d exp cafe0002 1 5", data1, busy1, busyCount); end
    endtask

    task automatic test_reset_mid;
        read1 = 5'd5; read2 = 5'd9;
        cycle(1, 5'd5, 32'hDEADBEEF, 0, 0);
        n_checks++; if (data1 !== 32'hDEADBEEF || busy2 !== 1'b1) begin n_fail++; $display("FAIL pre_reset got %h %b exp deadbeef 1", data1, busy2); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (data1 !== 32'h0) begin n_fail++; $display("FAIL midreset_data got %h exp 0", data1); end
        n_checks++; if (busyCount !== 6'd0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL midreset_busy cnt %0d busy %b%b exp 0 00", busyCount, busy1, busy2); end
        @(negedge clk);
        regWrite = 1'b1; writeReg = 5'd5; writeData = 32'h11111111;
        lockReq = 1'b1; lockReg = 5'd5;
        @(posedge clk);
        #1;
        regWrite = 1'b0; lockReq = 1'b0;
        n_checks++; if (data1 !== 32'h0 || busyCount !== 6'd0) begin n_fail++; $display("FAIL reset_override got %h %0d exp 0 0", data1, busyCount); end
        @(negedge clk);
        reset = 1'b1;
        cycle(1, 5'd5, 32'h22222222, 0, 0);
        n_checks++; if (data1 !== 32'h22222222) begin n_fail++; $display("FAIL post_reset_wr got %h exp 22222222", data1); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_scoreboard;
        test_simultaneous;
        test_bypass;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
